// File: rtl/snitch_dma_cmd_seq.sv
// -----------------------------------------------------------------------------
// snitch_dma_cmd_seq
//
// Hardware initiator for the Snitch DMA accelerator interface. A complete
// transfer descriptor is accepted in one handshake. It is then replayed as the
// DMSRC / DMDST / [DMSTR / DMREP] / DMCPY request sequence on the accelerator
// request channel. The transfer ID returned by DMCPY is captured. When the
// descriptor asks for it, DMSTAT (completed_id) is polled until that transfer
// has completed. The outcome is reported on the done channel.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   desc_*                  descriptor valid/ready handshake and fields
//   done_valid_o/ready_i    completion handshake
//   done_tid_o/error_o      captured transfer ID and error flag
//   acc_q*                  accelerator request channel (one request in flight)
//   acc_p*                  accelerator response channel (always ready)
//   busy_o                  sequencer is not idle
//
// AddrWidth must be > 32 and <= 64. DataWidth must be >= 32.
// -----------------------------------------------------------------------------
module snitch_dma_cmd_seq #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter logic [31:0] AccAddr   = 32'd0,
  parameter logic [4:0]  QId       = 5'd1,
  parameter int unsigned PollGap   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // descriptor
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [AddrWidth-1:0] desc_src_i,
  input  logic [AddrWidth-1:0] desc_dst_i,
  input  logic [DataWidth-1:0] desc_num_bytes_i,
  input  logic [DataWidth-1:0] desc_stride_src_i,
  input  logic [DataWidth-1:0] desc_stride_dst_i,
  input  logic [DataWidth-1:0] desc_num_reps_i,
  input  logic                 desc_decouple_i,
  input  logic                 desc_twod_i,
  input  logic                 desc_wait_i,
  // completion
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [31:0]          done_tid_o,
  output logic                 done_error_o,
  // accelerator request
  output logic [31:0]          acc_qaddr_o,
  output logic [4:0]           acc_qid_o,
  output logic [31:0]          acc_qdata_op_o,
  output logic [DataWidth-1:0] acc_qdata_arga_o,
  output logic [DataWidth-1:0] acc_qdata_argb_o,
  output logic [AddrWidth-1:0] acc_qdata_argc_o,
  output logic                 acc_qvalid_o,
  input  logic                 acc_qready_i,
  // accelerator response
  input  logic [DataWidth-1:0] acc_pdata_i,
  input  logic [4:0]           acc_pid_i,
  input  logic                 acc_perror_i,
  input  logic                 acc_pvalid_i,
  output logic                 acc_pready_o,
  output logic                 busy_o
);

  // Snitch DMA instruction encodings (riscv_instr::DM*) with all register
  // fields left at zero; the frontend decodes funct7 and the opcode only.
  localparam logic [31:0] OpDmSrc  = 32'h0000_002b;
  localparam logic [31:0] OpDmDst  = 32'h0200_002b;
  localparam logic [31:0] OpDmCpy  = 32'h0600_002b;
  localparam logic [31:0] OpDmStat = 32'h0a00_002b;
  localparam logic [31:0] OpDmStr  = 32'h0c00_002b;
  localparam logic [31:0] OpDmRep  = 32'h0e00_002b;

  // The gap counter holds PollGap-1 down to 0.
  localparam int unsigned   GapW    = (PollGap > 32'd1) ? $clog2(PollGap) : 32'd1;
  localparam logic [GapW-1:0] GapLoad = GapW'((PollGap > 32'd0) ? (PollGap - 32'd1) : 32'd0);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StSrc     = 4'd1,
    StDst     = 4'd2,
    StStr     = 4'd3,
    StRep     = 4'd4,
    StCpy     = 4'd5,
    StCpyRsp  = 4'd6,
    StPoll    = 4'd7,
    StPollRsp = 4'd8,
    StGap     = 4'd9,
    StDone    = 4'd10
  } state_e;

  // Lower address word, zero-extended to operand width.
  function automatic logic [DataWidth-1:0] addr_lo(input logic [AddrWidth-1:0] addr);
    return DataWidth'(addr[31:0]);
  endfunction

  // Upper address bits, zero-extended to operand width.
  function automatic logic [DataWidth-1:0] addr_hi(input logic [AddrWidth-1:0] addr);
    return DataWidth'(addr[AddrWidth-1:32]);
  endfunction

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   src_q, src_d;
  logic [AddrWidth-1:0]   dst_q, dst_d;
  logic [DataWidth-1:0]   num_bytes_q, num_bytes_d;
  logic [DataWidth-1:0]   stride_src_q, stride_src_d;
  logic [DataWidth-1:0]   stride_dst_q, stride_dst_d;
  logic [DataWidth-1:0]   num_reps_q, num_reps_d;
  logic                   decouple_q, decouple_d;
  logic                   twod_q, twod_d;
  logic                   wait_q, wait_d;
  logic [31:0]            tid_q, tid_d;
  logic                   err_q, err_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;

  logic                   req_valid_s;
  logic                   req_hs_s;
  logic                   rsp_err_s;
  logic [31:0]            poll_diff_s;
  logic                   poll_done_s;
  logic                   unused_pdata_s;

  // Response judgement shared by the DMCPY and DMSTAT response states.
  assign rsp_err_s   = acc_perror_i | (acc_pid_i != QId);
  // Wrap-safe "completed_id is past tid": signed difference strictly positive.
  assign poll_diff_s = acc_pdata_i[31:0] - tid_q;
  assign poll_done_s = ~poll_diff_s[31] & (poll_diff_s != 32'd0);
  assign req_hs_s    = req_valid_s & acc_qready_i;

  assign unused_pdata_s = ^acc_pdata_i[DataWidth-1:32];

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    num_bytes_d  = num_bytes_q;
    stride_src_d = stride_src_q;
    stride_dst_d = stride_dst_q;
    num_reps_d   = num_reps_q;
    decouple_d   = decouple_q;
    twod_d       = twod_q;
    wait_d       = wait_q;
    tid_d        = tid_q;
    err_d        = err_q;
    gap_cnt_d    = gap_cnt_q;

    case (state_q)
      StIdle: begin
        if (desc_valid_i) begin
          src_d        = desc_src_i;
          dst_d        = desc_dst_i;
          num_bytes_d  = desc_num_bytes_i;
          stride_src_d = desc_stride_src_i;
          stride_dst_d = desc_stride_dst_i;
          num_reps_d   = desc_num_reps_i;
          decouple_d   = desc_decouple_i;
          twod_d       = desc_twod_i;
          wait_d       = desc_wait_i;
          state_d      = StSrc;
        end else begin
          state_d = StIdle;
        end
      end

      StSrc: begin
        if (req_hs_s) begin
          state_d = StDst;
        end else begin
          state_d = StSrc;
        end
      end

      StDst: begin
        if (req_hs_s) begin
          state_d = twod_q ? StStr : StCpy;
        end else begin
          state_d = StDst;
        end
      end

      StStr: begin
        if (req_hs_s) begin
          state_d = StRep;
        end else begin
          state_d = StStr;
        end
      end

      StRep: begin
        if (req_hs_s) begin
          state_d = StCpy;
        end else begin
          state_d = StRep;
        end
      end

      StCpy: begin
        if (req_hs_s) begin
          state_d = StCpyRsp;
        end else begin
          state_d = StCpy;
        end
      end

      StCpyRsp: begin
        if (acc_pvalid_i) begin
          if (rsp_err_s) begin
            err_d   = 1'b1;
            tid_d   = 32'd0;
            state_d = StDone;
          end else begin
            tid_d   = acc_pdata_i[31:0];
            state_d = wait_q ? StPoll : StDone;
          end
        end else begin
          state_d = StCpyRsp;
        end
      end

      StPoll: begin
        if (req_hs_s) begin
          state_d = StPollRsp;
        end else begin
          state_d = StPoll;
        end
      end

      StPollRsp: begin
        if (acc_pvalid_i) begin
          if (rsp_err_s) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (poll_done_s) begin
            state_d = StDone;
          end else if (PollGap == 32'd0) begin
            state_d = StPoll;
          end else begin
            gap_cnt_d = GapLoad;
            state_d   = StGap;
          end
        end else begin
          state_d = StPollRsp;
        end
      end

      StGap: begin
        if (gap_cnt_q == {GapW{1'b0}}) begin
          state_d = StPoll;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(32'd1);
          state_d   = StGap;
        end
      end

      StDone: begin
        if (done_ready_i) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: handshakes and request payload depend on registered state only.
  always_comb begin
    desc_ready_o     = 1'b0;
    done_valid_o     = 1'b0;
    req_valid_s      = 1'b0;
    acc_qaddr_o      = 32'd0;
    acc_qid_o        = 5'd0;
    acc_qdata_op_o   = 32'd0;
    acc_qdata_arga_o = {DataWidth{1'b0}};
    acc_qdata_argb_o = {DataWidth{1'b0}};

    case (state_q)
      StIdle: begin
        desc_ready_o = 1'b1;
      end
      StSrc: begin
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmSrc;
        acc_qdata_arga_o = addr_lo(src_q);
        acc_qdata_argb_o = addr_hi(src_q);
      end
      StDst: begin
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmDst;
        acc_qdata_arga_o = addr_lo(dst_q);
        acc_qdata_argb_o = addr_hi(dst_q);
      end
      StStr: begin
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmStr;
        acc_qdata_arga_o = stride_src_q;
        acc_qdata_argb_o = stride_dst_q;
      end
      StRep: begin
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmRep;
        acc_qdata_arga_o = num_reps_q;
      end
      StCpy: begin
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmCpy;
        acc_qdata_arga_o = num_bytes_q;
        acc_qdata_argb_o = DataWidth'({twod_q, decouple_q});
      end
      StPoll: begin
        // Status index 0 selects completed_id.
        req_valid_s      = 1'b1;
        acc_qdata_op_o   = OpDmStat;
      end
      StDone: begin
        done_valid_o = 1'b1;
      end
      default: begin
        desc_ready_o = 1'b0;
      end
    endcase

    if (req_valid_s) begin
      acc_qaddr_o = AccAddr;
      acc_qid_o   = QId;
    end else begin
      acc_qaddr_o = 32'd0;
      acc_qid_o   = 5'd0;
    end
  end

  assign acc_qvalid_o     = req_valid_s;
  assign acc_qdata_argc_o = {AddrWidth{1'b0}};
  // Responses are always accepted so stray ones (e.g. from before a reset) drain.
  assign acc_pready_o     = 1'b1;
  assign busy_o           = (state_q != StIdle);
  assign done_tid_o       = tid_q;
  assign done_error_o     = err_q;

  // State and descriptor registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      src_q        <= {AddrWidth{1'b0}};
      dst_q        <= {AddrWidth{1'b0}};
      num_bytes_q  <= {DataWidth{1'b0}};
      stride_src_q <= {DataWidth{1'b0}};
      stride_dst_q <= {DataWidth{1'b0}};
      num_reps_q   <= {DataWidth{1'b0}};
      decouple_q   <= 1'b0;
      twod_q       <= 1'b0;
      wait_q       <= 1'b0;
      tid_q        <= 32'd0;
      err_q        <= 1'b0;
      gap_cnt_q    <= {GapW{1'b0}};
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      num_bytes_q  <= num_bytes_d;
      stride_src_q <= stride_src_d;
      stride_dst_q <= stride_dst_d;
      num_reps_q   <= num_reps_d;
      decouple_q   <= decouple_d;
      twod_q       <= twod_d;
      wait_q       <= wait_d;
      tid_q        <= tid_d;
      err_q        <= err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_snitch_dma_cmd_seq.sv
// -----------------------------------------------------------------------------
// Testbench for snitch_dma_cmd_seq. The bench plays the DMA frontend (request
// sink and response source). A stimulus process issues descriptors and pushes
// the expected request stream and completion into queues. A monitor process
// pops and compares whenever the DUT completes a request or done handshake.
// -----------------------------------------------------------------------------
module tb_snitch_dma_cmd_seq;
  localparam int          AW  = 48;
  localparam int          DW  = 64;
  localparam int          PG  = 4;
  localparam logic [4:0]  QID = 5'd1;
  localparam logic [31:0] DMSRC  = 32'h0000_002b;
  localparam logic [31:0] DMDST  = 32'h0200_002b;
  localparam logic [31:0] DMCPY  = 32'h0600_002b;
  localparam logic [31:0] DMSTAT = 32'h0a00_002b;
  localparam logic [31:0] DMSTR  = 32'h0c00_002b;
  localparam logic [31:0] DMREP  = 32'h0e00_002b;

  typedef struct packed {
    logic [AW-1:0] src, dst;
    logic [DW-1:0] nb, ss, sd, nr;
    logic dec, twod, wt;
  } desc_t;
  typedef struct packed { logic [31:0] op; logic [63:0] a; logic [63:0] b; } req_t;
  typedef struct { logic [31:0] tid; logic err; int lat; } done_t;

  logic clk = 1'b0, rst_ni;
  logic desc_valid_i, desc_ready_o;
  logic [AW-1:0] desc_src_i, desc_dst_i;
  logic [DW-1:0] desc_num_bytes_i, desc_stride_src_i, desc_stride_dst_i, desc_num_reps_i;
  logic desc_decouple_i, desc_twod_i, desc_wait_i;
  logic done_valid_o, done_ready_i, done_error_o;
  logic [31:0] done_tid_o, acc_qaddr_o, acc_qdata_op_o;
  logic [4:0] acc_qid_o, acc_pid_i;
  logic [DW-1:0] acc_qdata_arga_o, acc_qdata_argb_o, acc_pdata_i;
  logic [AW-1:0] acc_qdata_argc_o;
  logic acc_qvalid_o, acc_qready_i, acc_perror_i, acc_pvalid_i, acc_pready_o, busy_o;

  snitch_dma_cmd_seq #(.AddrWidth(AW), .DataWidth(DW), .AccAddr(32'd0), .QId(QID), .PollGap(PG)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i),
    .desc_num_bytes_i(desc_num_bytes_i), .desc_stride_src_i(desc_stride_src_i),
    .desc_stride_dst_i(desc_stride_dst_i), .desc_num_reps_i(desc_num_reps_i),
    .desc_decouple_i(desc_decouple_i), .desc_twod_i(desc_twod_i), .desc_wait_i(desc_wait_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_tid_o(done_tid_o), .done_error_o(done_error_o),
    .acc_qaddr_o(acc_qaddr_o), .acc_qid_o(acc_qid_o), .acc_qdata_op_o(acc_qdata_op_o),
    .acc_qdata_arga_o(acc_qdata_arga_o), .acc_qdata_argb_o(acc_qdata_argb_o),
    .acc_qdata_argc_o(acc_qdata_argc_o), .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready_i),
    .acc_pdata_i(acc_pdata_i), .acc_pid_i(acc_pid_i), .acc_perror_i(acc_perror_i),
    .acc_pvalid_i(acc_pvalid_i), .acc_pready_o(acc_pready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0;
  req_t  exp_req[$];
  done_t exp_done[$];

  // Frontend response plan for the descriptor in flight.
  logic [31:0] p_cpy_tid;
  logic        p_cpy_err, p_cpy_badpid;
  int          p_lat = 1;
  logic [31:0] p_poll_v[$];
  logic        p_poll_e[$];
  logic        rand_q = 1'b0, rand_done = 1'b0;
  int          stall_dst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: request stream and outcome from the descriptor and plan.
  task automatic model(input desc_t d, input int lat);
    logic [31:0] tid;
    done_t dn;
    exp_req.push_back('{DMSRC, 64'(d.src[31:0]), 64'(d.src >> 32)});
    exp_req.push_back('{DMDST, 64'(d.dst[31:0]), 64'(d.dst >> 32)});
    if (d.twod) begin
      exp_req.push_back('{DMSTR, d.ss, d.sd});
      exp_req.push_back('{DMREP, d.nr, 64'd0});
    end
    exp_req.push_back('{DMCPY, d.nb, (d.twod ? 64'd2 : 64'd0) + (d.dec ? 64'd1 : 64'd0)});
    if (p_cpy_err || p_cpy_badpid) begin
      dn = '{32'd0, 1'b1, lat};
    end else begin
      tid = p_cpy_tid;
      dn = '{tid, 1'b0, lat};
      if (d.wt) begin
        dn = '{tid, 1'b1, lat};
        for (int k = 0; k < p_poll_v.size(); k++) begin
          exp_req.push_back('{DMSTAT, 64'd0, 64'd0});
          if (p_poll_e[k]) break;
          if ($signed(p_poll_v[k] - tid) > 0) begin
            dn = '{tid, 1'b0, lat};
            break;
          end
        end
      end
    end
    exp_done.push_back(dn);
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    d.src  = AW'({$urandom, $urandom});
    d.dst  = AW'({$urandom, $urandom});
    d.nb   = {$urandom, $urandom};
    d.ss   = {$urandom, $urandom};
    d.sd   = {$urandom, $urandom};
    d.nr   = {$urandom, $urandom};
    d.dec  = 1'($urandom_range(0, 1));
    d.twod = 1'($urandom_range(0, 1));
    d.wt   = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    desc_src_i = d.src; desc_dst_i = d.dst; desc_num_bytes_i = d.nb;
    desc_stride_src_i = d.ss; desc_stride_dst_i = d.sd; desc_num_reps_i = d.nr;
    desc_decouple_i = d.dec; desc_twod_i = d.twod; desc_wait_i = d.wt;
  endtask

  task automatic set_plan(input logic [31:0] tid, input logic cerr, input logic bpid, input int lat);
    p_cpy_tid = tid; p_cpy_err = cerr; p_cpy_badpid = bpid; p_lat = lat;
    p_poll_v.delete(); p_poll_e.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_desc_ready"}, 64'(desc_ready_o), 64'd1);
    check({tag, "_qvalid"},     64'(acc_qvalid_o), 64'd0);
    check({tag, "_done_valid"}, 64'(done_valid_o), 64'd0);
    check({tag, "_busy"},       64'(busy_o), 64'd0);
    check({tag, "_payload"},    64'(acc_qdata_op_o) | acc_qdata_arga_o | acc_qdata_argb_o | 64'(acc_qdata_argc_o), 64'd0);
    check({tag, "_tid_err"},    {31'd0, done_error_o, done_tid_o}, 64'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one descriptor and wait (bounded) for its completion handshake.
  task automatic run_desc(input desc_t d, input int lat_chk);
    int start, t;
    logic hs;
    start = done_cnt;
    model(d, lat_chk);
    @(posedge clk); #1;
    drive_desc(d);
    desc_valid_i = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = desc_ready_o;
      @(posedge clk); #1; t++;
    end
    desc_valid_i = 1'b0;
    drive_desc(rand_desc());
    t = 0;
    while (done_cnt == start && t < 3000) begin
      @(posedge clk); t++;
    end
    if (done_cnt == start) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no completion after %0d cycles, required one", t);
      do_reset(2);
      exp_req.delete(); exp_done.delete(); stall_dst = 0;
      rst_ni = 1'b1;
    end else begin
      check("req_leftover", 64'(exp_req.size()), 64'd0);
    end
  endtask

  // Frontend model: qready/done_ready stimulus and DMCPY/DMSTAT responses.
  initial begin : driver
    int pend;
    logic [63:0] pd;
    logic pe, hs, took;
    logic [4:0] pid;
    logic [31:0] hop;
    pend = 0; pd = 64'd0; pe = 1'b0; pid = QID;
    forever begin
      @(negedge clk);
      hs = acc_qvalid_o && acc_qready_i;
      hop = acc_qdata_op_o;
      took = acc_pvalid_i && acc_pready_o;
      @(posedge clk); #1;
      if (took) begin
        acc_pvalid_i = 1'b0; acc_perror_i = 1'b0; acc_pdata_i = 64'd0; acc_pid_i = 5'd0;
      end
      if (hs && hop == DMCPY) begin
        pend = p_lat;
        pd   = {$urandom, p_cpy_tid};
        pe   = p_cpy_err;
        pid  = p_cpy_badpid ? QID + 5'($urandom_range(1, 31)) : QID;
      end else if (hs && hop == DMSTAT) begin
        pend = p_lat;
        pid  = QID;
        if (p_poll_v.size() > 0) begin
          pd = {$urandom, p_poll_v.pop_front()};
          pe = p_poll_e.pop_front();
        end else begin
          pd = 64'd0; pe = 1'b1;
        end
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          acc_pvalid_i = 1'b1; acc_pdata_i = pd; acc_perror_i = pe; acc_pid_i = pid;
        end
      end
      acc_qready_i = rand_q ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_dst > 0 && acc_qvalid_o && acc_qdata_op_o == DMDST) begin
        acc_qready_i = 1'b0;
        stall_dst--;
      end
      done_ready_i = rand_done ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor: compares every request/done handshake against the queues.
  initial begin : monitor
    req_t r; done_t dn;
    logic stalled, dstall, pdv, rsp_poll;
    logic [31:0] s_op, s_tid, last_op;
    logic [63:0] s_a, s_b;
    logic s_err;
    int acc_c, rsp_c;
    stalled = 1'b0; dstall = 1'b0; pdv = 1'b0; rsp_poll = 1'b0; last_op = 32'd0;
    s_op = 32'd0; s_a = 64'd0; s_b = 64'd0; s_tid = 32'd0; s_err = 1'b0;
    acc_c = 0; rsp_c = -100;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        stalled = 1'b0; dstall = 1'b0; pdv = 1'b0; rsp_poll = 1'b0; rsp_c = -100;
      end else begin
        if (desc_valid_i && desc_ready_o) acc_c = cyc;
        if (acc_pvalid_i) begin
          check("pready", 64'(acc_pready_o), 64'd1);
          rsp_c = cyc; rsp_poll = (last_op == DMSTAT);
        end
        if (stalled) begin
          check("qvalid_hold", 64'(acc_qvalid_o), 64'd1);
          check("op_hold", 64'(acc_qdata_op_o), 64'(s_op));
          check("arga_hold", acc_qdata_arga_o, s_a);
          check("argb_hold", acc_qdata_argb_o, s_b);
        end
        stalled = 1'b0;
        if (acc_qvalid_o) begin
          check("argc", 64'(acc_qdata_argc_o), 64'd0);
          check("qid_qaddr", {27'd0, acc_qid_o, acc_qaddr_o}, {27'd0, QID, 32'd0});
          if (acc_qready_i) begin
            last_op = acc_qdata_op_o;
            if (exp_req.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_req: got op %h, required no request", acc_qdata_op_o);
            end else begin
              r = exp_req.pop_front();
              check("req_op", 64'(acc_qdata_op_o), 64'(r.op));
              check("req_arga", acc_qdata_arga_o, r.a);
              check("req_argb", acc_qdata_argb_o, r.b);
              if (r.op == DMSTAT && rsp_poll)
                check("poll_gap_ok", 64'(cyc - rsp_c >= PG + 1), 64'd1);
            end
          end else begin
            stalled = 1'b1;
            s_op = acc_qdata_op_o; s_a = acc_qdata_arga_o; s_b = acc_qdata_argb_o;
          end
        end
        if (dstall) begin
          check("done_valid_hold", 64'(done_valid_o), 64'd1);
          check("done_hold", {31'd0, done_error_o, done_tid_o}, {31'd0, s_err, s_tid});
        end
        if (done_valid_o && !pdv && exp_done.size() > 0 && exp_done[0].lat >= 0)
          check("done_latency", 64'(cyc - acc_c), 64'(exp_done[0].lat));
        if (done_valid_o && done_ready_i) begin
          if (exp_done.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got tid %h, required no completion", done_tid_o);
          end else begin
            dn = exp_done.pop_front();
            check("done_tid", 64'(done_tid_o), 64'(dn.tid));
            check("done_err", 64'(done_error_o), 64'(dn.err));
          end
          done_cnt++;
        end
        dstall = done_valid_o && !done_ready_i;
        s_tid = done_tid_o; s_err = done_error_o;
        pdv = done_valid_o;
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized descriptors.
  initial begin : stimulus
    desc_t d;
    logic seen;
    int k;
    rst_ni = 1'b0; desc_valid_i = 1'b0; done_ready_i = 1'b1; acc_qready_i = 1'b1;
    acc_pvalid_i = 1'b0; acc_pdata_i = 64'd0; acc_pid_i = 5'd0; acc_perror_i = 1'b0;
    drive_desc('0);
    set_plan(32'd0, 1'b0, 1'b0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); check_idle("in_reset");
    @(posedge clk); #1; rst_ni = 1'b1;
    @(negedge clk); check_idle("after_reset");

    // 1D, no wait, response one cycle after DMCPY: done_valid five cycles after accept.
    d = '0; d.src = 48'h12_3456_7890; d.dst = 48'h0_1000; d.nb = 64'd256;
    set_plan(32'd7, 1'b0, 1'b0, 1);
    run_desc(d, 5);

    // 2D, decoupled.
    d = '0; d.src = 48'hA_0000_0040; d.dst = 48'h2_0000; d.nb = 64'd512;
    d.ss = 64'd64; d.sd = 64'd128; d.nr = 64'd4; d.twod = 1'b1; d.dec = 1'b1;
    set_plan(32'd20, 1'b0, 1'b0, 1);
    run_desc(d, 5 + 2);

    // Wait with polling: 8 and 9 are not past tid 9, 10 is.
    d = '0; d.src = 48'h100; d.dst = 48'h200; d.nb = 64'd8; d.wt = 1'b1;
    set_plan(32'd9, 1'b0, 1'b0, 1);
    p_poll_v = '{32'd8, 32'd9, 32'd10}; p_poll_e = '{1'b0, 1'b0, 1'b0};
    run_desc(d, -1);

    // Wrap-around of the transfer ID.
    set_plan(32'hFFFF_FFFF, 1'b0, 1'b0, 2);
    p_poll_v = '{32'hFFFF_FFFF, 32'h0000_0000}; p_poll_e = '{1'b0, 1'b0};
    run_desc(d, -1);

    // DMCPY error, then DMCPY with a foreign response ID: no DMSTAT either way.
    set_plan(32'd55, 1'b1, 1'b0, 1);
    p_poll_v = '{32'd100}; p_poll_e = '{1'b0};
    run_desc(d, -1);
    set_plan(32'd56, 1'b0, 1'b1, 3);
    p_poll_v = '{32'd100}; p_poll_e = '{1'b0};
    run_desc(d, -1);

    // Back-pressure: DST held for 10 cycles.
    d = '0; d.src = 48'hBEEF_0000_1234; d.dst = 48'hCAFE_0000_5678; d.nb = 64'd64;
    set_plan(32'd3, 1'b0, 1'b0, 1);
    stall_dst = 10;
    run_desc(d, 5 + 10);

    // Reset while waiting for the DMCPY response; that response then arrives in IDLE.
    set_plan(32'd77, 1'b0, 1'b0, 6);
    model(d, -1);
    void'(exp_done.pop_back());
    @(posedge clk); #1;
    drive_desc(d); desc_valid_i = 1'b1;
    @(posedge clk); #1; desc_valid_i = 1'b0;
    k = 0;
    while (exp_req.size() != 0 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("cpy_issued_before_reset", 64'(exp_req.size()), 64'd0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check_idle("mid_reset");
    @(posedge clk); #1; rst_ni = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk); seen = seen | busy_o | done_valid_o | acc_qvalid_o;
    end
    check("stale_rsp_ignored", 64'(seen), 64'd0);
    d = '0; d.src = 48'h1_2345_6789; d.dst = 48'h9_8765_4321; d.nb = 64'd1024;
    set_plan(32'd88, 1'b0, 1'b0, 1);
    run_desc(d, 5);

    // Randomized descriptors with random back-pressure, latency, errors and polls.
    rand_q = 1'b1; rand_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] tid;
      int nf;
      d = rand_desc();
      tid = $urandom;
      set_plan(tid, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0), int'($urandom_range(1, 4)));
      nf = int'($urandom_range(0, 3));
      for (int j = 0; j < nf; j++) begin
        p_poll_v.push_back(tid - $urandom_range(0, 1000));
        p_poll_e.push_back(1'($urandom_range(0, 11) == 0));
      end
      p_poll_v.push_back(tid + $urandom_range(1, 1000));
      p_poll_e.push_back(1'($urandom_range(0, 11) == 0));
      run_desc(d, -1);
    end

    repeat (5) @(posedge clk);
    check("done_leftover", 64'(exp_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, required completion within budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snitch_dma_cmd_seq.md
# snitch_dma_cmd_seq

Hardware initiator for the Snitch DMA accelerator interface. It accepts a complete transfer descriptor, replays it as the DMSRC/DMDST/DMSTR/DMREP/DMCPY request sequence on the accelerator request channel, and captures the returned transfer ID. Optionally, it polls DMSTAT until that transfer has completed. It sits where a Snitch core would otherwise drive the DMA frontend, so fixed-function engines can launch DMA transfers without a core.

## Interface
- AddrWidth, 48: DMA address width; must be > 32 and ≤ 64.
- DataWidth, 64: accelerator operand width.
- AccAddr, 32'd0: value driven on acc_qaddr_o.
- QId, 5'd1: value driven on acc_qid_o; the expected acc_pid_i.
- PollGap, 4: idle cycles between a DMSTAT response and the next DMSTAT request; 0 means back-to-back.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake.
- desc_src_i, desc_dst_i  in  AddrWidth  source and destination addresses.
- desc_num_bytes_i, desc_stride_src_i, desc_stride_dst_i, desc_num_reps_i  in  DataWidth  transfer size, 2D strides, 2D repetitions.
- desc_decouple_i, desc_twod_i, desc_wait_i  in  1  decouple R/W; 2D transfer; poll until complete.
- done_valid_o / done_ready_i  out/in  1  completion handshake.
- done_tid_o  out  32  transfer ID returned by DMCPY.
- done_error_o  out  1  error on DMCPY or DMSTAT response.
- acc_qaddr_o  out  32  accelerator request address.
- acc_qid_o  out  5  accelerator request ID.
- acc_qdata_op_o  out  32  opcode.
- acc_qdata_arga_o, acc_qdata_argb_o  out  DataWidth  operands A and B.
- acc_qdata_argc_o  out  AddrWidth  operand C.
- acc_qvalid_o / acc_qready_i  out/in  1  request handshake.
- acc_pdata_i  in  DataWidth  response data.
- acc_pid_i  in  5  response ID.
- acc_perror_i, acc_pvalid_i  in  1  response error and valid.
- acc_pready_o  out  1  response ready.
- busy_o  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, SRC, DST, STR, REP, CPY, CPY_RSP, POLL, POLL_RSP, GAP, DONE.
- IDLE: desc_ready_o=1. On handshake, latch every descriptor field into registers and go to SRC. Later input changes have no effect.
- Each request state drives acc_qvalid_o=1 and advances on acc_qvalid_o & acc_qready_i. acc_qvalid_o and the request payload stay stable until that handshake.
- Request payloads (acc_qdata_argc_o is always 0; unused operands are 0):
  - SRC: op = riscv_instr::DMSRC; arga = src[31:0] zero-extended; argb = src[AddrWidth-1:32] zero-extended.
  - DST: op = riscv_instr::DMDST; operands as SRC, using dst.
  - STR: op = riscv_instr::DMSTR; arga = stride_src; argb = stride_dst.
  - REP: op = riscv_instr::DMREP; arga = num_reps.
  - CPY: op = riscv_instr::DMCPY; arga = num_bytes; argb = {.., twod, decouple}, with bit0 = decouple, bit1 = twod, all other bits 0.
  - POLL: op = riscv_instr::DMSTAT; argb = 0 (status index 0, completed_id).
- Sequence:
  - DST goes to STR if twod=1, else to CPY. STR goes to REP, and REP goes to CPY.
  - SRC/DST/STR/REP never produce responses.
- CPY_RSP: on acc_pvalid_i, latch tid = acc_pdata_i[31:0]. If acc_perror_i=1 or acc_pid_i≠QId, set the error flag and tid=0, then go to DONE. Otherwise go to POLL if wait=1, else to DONE.
- POLL_RSP, on acc_pvalid_i:
  - On error (same rule as CPY_RSP): set the error flag and go to DONE.
  - Complete when the signed 32-bit value (acc_pdata_i[31:0] − tid) > 0, which is wrap-safe. Then go to DONE.
  - Otherwise go to GAP.
- GAP: count PollGap cycles, then go to POLL. If PollGap=0, go straight to POLL.
- DONE: done_valid_o=1 with stable done_tid_o and done_error_o. On done_ready_i, go to IDLE and clear the error flag.
- acc_pready_o=1 in every state. A response arriving outside CPY_RSP/POLL_RSP is consumed and discarded, which drains a response left over from before a reset.
- Exactly one request is outstanding at a time.

## Timing
- During reset, and on the cycle after it: state=IDLE, acc_qvalid_o=0, done_valid_o=0, busy_o=0, desc_ready_o=1, all payload outputs 0, error flag 0, tid=0.
- desc_ready_o, acc_qvalid_o, done_valid_o and busy_o are decoded from registered state only. There is no combinational path from any *_ready_i to any *_valid_o.
- 1D, no wait, all ready, response one cycle after the CPY handshake:
  - descriptor accepted in cycle 0;
  - SRC, DST and CPY handshakes in cycles 1, 2 and 3;
  - response in cycle 4;
  - done_valid_o in cycle 5.
- A 2D transfer adds 2 cycles for STR and REP.
- Each unsuccessful poll adds (response latency + PollGap + 1) cycles.
- Reset asserted mid-sequence returns to IDLE on the next edge with no request emitted. A pending DMSTAT or DMCPY response is later discarded.
- A response arriving in the same cycle as the request handshake is not possible and need not be handled.

## Test plan
- 1D, wait=0, src=48'h12_3456_7890, dst=48'h0_1000, num_bytes=256, response data 7:
  - required: ops DMSRC (arga=32'h3456_7890, argb=16'h12), DMDST, DMCPY (argb=0), in that order;
  - required: done_tid_o=7, done_error_o=0, done_valid_o in cycle 5.
- 2D, decouple=1, strides 64/128, reps 4:
  - required: DMSTR (arga=64, argb=128) and DMREP (arga=4) between DMDST and DMCPY;
  - required: DMCPY argb=3.
- wait=1, tid=9, PollGap=4, DMSTAT responses 8, 9, 10:
  - required: exactly 3 DMSTAT requests, each at least 5 cycles after the previous response;
  - required: done_tid_o=9.
- Wrap-around, tid=32'hFFFF_FFFF, wait=1, DMSTAT returns 32'hFFFF_FFFF then 0:
  - required: completion on the second poll.
- DMCPY response with perror=1:
  - required: done_error_o=1, done_tid_o=0, no DMSTAT issued.
  - A separate run with acc_pid_i≠QId gives the same result.
- Back-pressure and reset:
  - acc_qready_i held 0 for 10 cycles in DST: payload stable throughout;
  - rst_ni low in CPY_RSP, then a response arrives in IDLE: response consumed, no done_valid_o, next descriptor runs normally.
